// File: rtl/hdmi_timing_ctrl.sv
// Video raster generator and pixel-stream sequencer for the HDMI transmitter.
// Locks an SOF-marked pixel stream to the raster and recovers from underflow/misalignment.
module hdmi_timing_ctrl #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter logic [23:0] FILL_RGB = 24'h000000
) (
   input  logic        PXLCLK_I,
   input  logic        RSTN_I,
   input  logic        ENABLE_I,
   input  logic        PIX_VALID_I,
   input  logic [23:0] PIX_DATA_I,
   input  logic        PIX_SOF_I,
   output logic        PIX_READY_O,
   output logic        VGA_HS_O,
   output logic        VGA_VS_O,
   output logic        VGA_DE_O,
   output logic [23:0] VGA_RGB_O,
   output logic        FRAME_START_O,
   input  logic        ERR_CLR_I,
   output logic        UNDERFLOW_O,
   output logic        SOF_ERR_O
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   typedef enum logic [1:0] {IDLE, SYNC_WAIT, ARMED, RUN} state_e;

   state_e          state_q, state_d;
   logic [HW-1:0]   h_cnt_q, h_cnt_d;
   logic [VW-1:0]   v_cnt_q, v_cnt_d;
   logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
   logic            uf_q, uf_d, se_q, se_d;
   logic [23:0]     rgb_q, rgb_d;
   logic            h_last, active, first, frame_end, hs_win, vs_win;
   logic            ready, uf_set, se_set;

   assign h_last    = (32'(h_cnt_q) == H_TOTAL - 1);
   assign frame_end = h_last && (32'(v_cnt_q) == V_TOTAL - 1);
   assign active    = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
   assign first     = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign hs_win    = (32'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                      (32'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
   assign vs_win    = (32'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                      (32'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);

   // Stream faults detected while running; both force a relock.
   assign uf_set = (state_q == RUN) && active && !PIX_VALID_I;
   assign se_set = (state_q == RUN) && active && PIX_VALID_I && (PIX_SOF_I != first);

   // State register
   always_ff @(posedge PXLCLK_I or negedge RSTN_I) begin
      if (!RSTN_I) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; shutdown at frame_end overrides everything
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (ENABLE_I) state_d = SYNC_WAIT;
         SYNC_WAIT: if (PIX_VALID_I && PIX_SOF_I) state_d = ARMED;
         ARMED:     if (frame_end) state_d = RUN;
         RUN:       if (uf_set || se_set) state_d = SYNC_WAIT;
         default:   state_d = IDLE;
      endcase
      if ((state_q != IDLE) && frame_end && !ENABLE_I) state_d = IDLE;
   end

   // Output logic: handshake and next values of the registered outputs
   always_comb begin
      ready = 1'b0;
      hs_d  = ~HS_POL;
      vs_d  = ~VS_POL;
      de_d  = 1'b0;
      rgb_d = '0;
      fs_d  = 1'b0;
      case (state_q)
         SYNC_WAIT: ready = !PIX_SOF_I;
         RUN:       ready = active && !(PIX_SOF_I && !first);
         default:   ready = 1'b0;
      endcase
      if (state_q != IDLE) begin
         hs_d = hs_win ? HS_POL : ~HS_POL;
         vs_d = vs_win ? VS_POL : ~VS_POL;
         de_d = active;
         fs_d = first;
         if (active)
            rgb_d = ((state_q == RUN) && PIX_VALID_I && ready) ? PIX_DATA_I : FILL_RGB;
      end
      uf_d = uf_set || (uf_q && !ERR_CLR_I);
      se_d = se_set || (se_q && !ERR_CLR_I);
   end

   // Raster counters, frozen at the origin while idle
   always_comb begin
      h_cnt_d = '0;
      v_cnt_d = '0;
      if (state_q != IDLE) begin
         h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
         v_cnt_d = v_cnt_q;
         if (h_last) v_cnt_d = (32'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + VW'(1);
      end
   end

   always_ff @(posedge PXLCLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         de_q    <= 1'b0;
         rgb_q   <= '0;
         fs_q    <= 1'b0;
         uf_q    <= 1'b0;
         se_q    <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         de_q    <= de_d;
         rgb_q   <= rgb_d;
         fs_q    <= fs_d;
         uf_q    <= uf_d;
         se_q    <= se_d;
      end
   end

   assign PIX_READY_O   = ready;
   assign VGA_HS_O      = hs_q;
   assign VGA_VS_O      = vs_q;
   assign VGA_DE_O      = de_q;
   assign VGA_RGB_O     = rgb_q;
   assign FRAME_START_O = fs_q;
   assign UNDERFLOW_O   = uf_q;
   assign SOF_ERR_O     = se_q;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Randomized bench for hdmi_timing_ctrl against a frame-position reference model.
module tb_hdmi_timing_ctrl;

   localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
   localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FT = HT * VT;
   localparam logic [23:0] FILL = 24'h102030;
   localparam int M_IDLE = 0, M_WAIT = 1, M_ARMED = 2, M_RUN = 3;

   logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, clr = 1'b0;
   logic        valid = 1'b0, sof = 1'b0;
   logic [23:0] data = '0;
   logic        ready, hs, vs, de, fs, uf, se;
   logic [23:0] rgb;

   hdmi_timing_ctrl #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0), .FILL_RGB(FILL)
   ) dut (
      .PXLCLK_I(clk), .RSTN_I(rst_n), .ENABLE_I(en),
      .PIX_VALID_I(valid), .PIX_DATA_I(data), .PIX_SOF_I(sof), .PIX_READY_O(ready),
      .VGA_HS_O(hs), .VGA_VS_O(vs), .VGA_DE_O(de), .VGA_RGB_O(rgb),
      .FRAME_START_O(fs), .ERR_CLR_I(clr), .UNDERFLOW_O(uf), .SOF_ERR_O(se)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sof;
      logic [23:0] data;
      int          gap;
   } beat_t;

   beat_t q[$];
   int    n_chk = 0, n_err = 0;
   int    m_mode = M_IDLE, m_pos = 0;
   logic  e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0, e_uf = 1'b0, e_se = 1'b0;
   logic [23:0] e_rgb = '0;
   int    cycle = 0, last_fs = -1, de_cnt = 0;
   bit    mon_on = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_beats(input int n, input int base, input int sof_idx,
                             input int gap_idx, input bit rnd);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.sof  = (i == sof_idx);
         b.data = 24'(base + i);
         b.gap  = (i == gap_idx) ? 1 :
                  (rnd && $urandom_range(0, 24) == 0) ? int'($urandom_range(1, 3)) : 0;
         q.push_back(b);
      end
   endtask

   task automatic drive_inputs();
      if (q.size() > 0) begin
         sof   = q[0].sof;
         data  = q[0].data;
         valid = (q[0].gap == 0);
      end else begin
         valid = 1'b0;
         sof   = 1'($urandom_range(0, 1));
         data  = 24'($urandom);
      end
   endtask

   // One pixel clock: predict from frame position, compare ready and the registered outputs.
   task automatic step();
      int h, v, nm;
      bit act, fst, fend, idle, rdy, ufs, ses;
      beat_t b;
      drive_inputs();
      #1;
      h    = m_pos % HT;
      v    = m_pos / HT;
      idle = (m_mode == M_IDLE);
      act  = (h < HA) && (v < VA);
      fst  = (m_pos == 0);
      fend = (m_pos == FT - 1);
      case (m_mode)
         M_WAIT:  rdy = !sof;
         M_RUN:   rdy = act && !(sof && !fst);
         default: rdy = 1'b0;
      endcase
      chk("ready", 32'(ready), 32'(rdy));
      e_hs  = idle || !(h >= HA + HFP && h < HA + HFP + HSY);
      e_vs  = idle || !(v >= VA + VFP && v < VA + VFP + VSY);
      e_de  = !idle && act;
      e_rgb = !e_de ? 24'h0 : ((m_mode == M_RUN) && valid && rdy) ? data : FILL;
      e_fs  = !idle && fst;
      ufs   = (m_mode == M_RUN) && act && !valid;
      ses   = (m_mode == M_RUN) && act && valid && (sof != fst);
      e_uf  = ufs || (e_uf && !clr);
      e_se  = ses || (e_se && !clr);
      nm = m_mode;
      case (m_mode)
         M_IDLE:  if (en) nm = M_WAIT;
         M_WAIT:  if (valid && sof) nm = M_ARMED;
         M_ARMED: if (fend) nm = M_RUN;
         default: if (ufs || ses) nm = M_WAIT;
      endcase
      if (!idle && fend && !en) nm = M_IDLE;
      m_pos  = idle ? 0 : (m_pos + 1) % FT;
      m_mode = nm;
      if (valid && rdy) b = q.pop_front();
      else if (q.size() > 0 && q[0].gap > 0) begin
         b = q[0];
         b.gap--;
         q[0] = b;
      end
      @(posedge clk);
      #1;
      chk("hs", 32'(hs), 32'(e_hs));
      chk("vs", 32'(vs), 32'(e_vs));
      chk("de", 32'(de), 32'(e_de));
      chk("rgb", 32'(rgb), 32'(e_rgb));
      chk("frame_start", 32'(fs), 32'(e_fs));
      chk("underflow", 32'(uf), 32'(e_uf));
      chk("sof_err", 32'(se), 32'(e_se));
      if (fs) begin
         if (mon_on && last_fs >= 0) begin
            chk("fs_period", 32'(cycle - last_fs), 32'(FT));
            chk("de_per_frame", 32'(de_cnt), 32'(HA * VA));
         end
         last_fs = cycle;
         de_cnt  = 0;
      end
      if (de) de_cnt++;
      cycle++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_hs"}, 32'(hs), 32'd1);
      chk({tag, "_vs"}, 32'(vs), 32'd1);
      chk({tag, "_de"}, 32'(de), 32'd0);
      chk({tag, "_rgb"}, 32'(rgb), 32'd0);
      chk({tag, "_fs"}, 32'(fs), 32'd0);
      chk({tag, "_flags"}, {30'd0, uf, se}, 32'd0);
      chk({tag, "_ready"}, 32'(ready), 32'd0);
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_pos = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = '0; e_fs = 1'b0; e_uf = 1'b0; e_se = 1'b0;
   endtask

   // Asynchronous reset in the middle of a clock phase, then hold and release.
   task automatic mid_reset();
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_rst");
      model_reset();
      en = 1'b0;
      q.delete();
      @(negedge clk);
      run(3);
      rst_n = 1'b1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 check_reset_values("rst");
      model_reset();
      @(negedge clk);
      run(3);
      rst_n = 1'b1;

      // Idle: beats offered must never be taken
      push_beats(3, 24'h500, 0, -1, 1'b0);
      run(40);
      q.delete();

      // Free-running raster with no source
      en = 1'b1;
      mon_on = 1'b1;
      run(2 * FT + 5);
      mon_on = 1'b0;

      // Lock: 5 stale beats drained, then an SOF-aligned frame of 0..31
      push_beats(5, 24'hABC000, -1, -1, 1'b0);
      push_beats(HA * VA, 0, 0, -1, 1'b0);
      run(3 * FT);

      // Underflow at pixel 13, relock on next frame, then clear
      clr = 1'b1; step(); clr = 1'b0;
      push_beats(HA * VA, 24'h1000, 0, 13, 1'b0);
      push_beats(HA * VA, 24'h2000, 0, -1, 1'b0);
      run(4 * FT);
      clr = 1'b1; step(); clr = 1'b0;
      run(10);

      // SOF arriving on beat 5
      push_beats(HA * VA, 24'h3000, 0, -1, 1'b0);
      push_beats(5, 24'h4000, 0, -1, 1'b0);
      push_beats(HA * VA, 24'h5000, 0, -1, 1'b0);
      run(5 * FT);
      clr = 1'b1; step(); clr = 1'b0;

      // Shutdown mid-frame, then reset mid-line
      run(40);
      en = 1'b0;
      run(FT + 30);
      en = 1'b1;
      run(FT + 20);
      mid_reset();
      en = 1'b1;

      // Randomized traffic, faults, clears and shutdowns
      for (int i = 0; i < 30 * FT; i++) begin
         if (q.size() < 40) begin
            case ($urandom_range(0, 9))
               0:       push_beats(HA * VA, int'($urandom_range(0, 24'hFFF000)), -1, -1, 1'b1);
               1:       push_beats(HA * VA, int'($urandom_range(0, 24'hFFF000)),
                                   int'($urandom_range(1, HA * VA - 1)), -1, 1'b1);
               default: push_beats(HA * VA, int'($urandom_range(0, 24'hFFF000)), 0, -1, 1'b1);
            endcase
         end
         en  = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 49) == 0);
         step();
      end
      clr = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
